csa_resolve: RTL
================

// Module: csa_resolve
// PURPOSE
//  Carry-propagate stage directly downstream of the 25-bit carry-save adder: consumes its sum/carry
//  vector pair and resolves it to one binary result. Multi-cycle: ripples CHUNK bits per clock to
//  keep the adder small. Sits between the CSA reduction and mantissa normalise/round logic.
//  Valid/ready handshake on input and output.
// PARAMETERS
//  W      25  width of the incoming s / c vectors
//  CHUNK   5  bits resolved per clock; NCH = ceil((W+2)/CHUNK) chunks (6 at defaults)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      s_in/c_in valid
//  in_ready   out  1      block accepts a pair this cycle
//  s_in       in   W      CSA sum vector
//  c_in       in   W      CSA carry vector, weight 2 (bit i carries weight 2^(i+1))
//  out_valid  out  1      out_sum valid
//  out_ready  in   1      consumer takes out_sum
//  out_sum    out  W+2    s_in + (c_in<<1), exact, zero-extended
//  zero       out  1      only with CSA_RESOLVE_ZERO_EN; out_sum == 0
// BEHAVIOUR
//  - Reset (async assert, sync deassert by design): state=IDLE, idx=0, carry=0, in_ready=1,
//    out_valid=0, out_sum=0, zero=0. Reset asserted mid-operation aborts it; the pair is lost.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE: in_ready=1. in_valid&in_ready at an edge latches A={2'b0,s_in}, B={1'b0,c_in,1'b0},
//    both zero-padded to NCH*CHUNK bits. Goes to BUSY with idx=0, carry=0.
//  - BUSY: in_ready=0. Each edge adds A/B chunk idx plus carry and writes result chunk idx.
//    The chunk carry-out goes to carry, then idx++. At idx==NCH-1 the edge goes to DONE.
//  - Latency: out_valid rises exactly NCH edges after the accept edge.
//  - DONE: out_valid=1; out_sum (and zero) held stable until out_valid&out_ready.
//    That edge goes to IDLE and clears out_valid. in_ready=0 in DONE; no overlap.
//    Throughput is one pair per NCH+2 cycles minimum.
//  - Width: the max of s + 2c is 3*(2^W-1), which fits W+2 bits. The final chunk carry is always 0
//    due to padding and is discarded. No overflow output.
//  - in_valid while busy is ignored; the upstream holds the data (standard valid/ready).
//  - out_sum is registered only, no combinational path from inputs.
// CONFIGURATION
//  - `CSA_RESOLVE_ZERO_EN defined: zero port present.
//    zero is set in DONE = (out_sum==0), accumulated per chunk during BUSY, no extra latency.
//    Reset 0, held with out_sum.
//  - Undefined: zero port and its logic absent; all else identical.
// STRUCTURE
//  - Shared package csa_pkg: state enum {IDLE,BUSY,DONE}, function nch(W,CHUNK), default W/CHUNK
//    localparams. Reused by the other CSA-path blocks.
//  - One sub-module csa_chunk_add (CHUNK-bit ripple adder of FA2 cells, cin/cout).
//    Instantiated once; this block muxes chunk idx into it.
// TESTING (W=25, CHUNK=5, NCH=6)
//  - s=0, c=0 -> out_sum=0. out_valid rises 6 edges after accept. zero=1 when macro defined.
//  - s=0x1FFFFFF, c=0x1FFFFFF -> out_sum=0x5FFFFFD (top bit used, no loss).
//  - s=0x000001F, c=0x0000001 -> out_sum=0x21. Carry crosses chunk0->chunk1. zero=0.
//  - Backpressure: out_ready=0 for 4 cycles after out_valid -> out_sum, out_valid stable,
//    in_ready=0. Then out_ready=1 -> IDLE next edge, in_ready=1.
//  - rst_n pulsed low during BUSY at idx=3 -> out_valid=0, in_ready=1 immediately.
//    Next pair s=0x0000100, c=0x0000080 -> 0x200.
//  - Back-to-back: in_valid held high with 3 different pairs, out_ready=1 -> each accepted once.
//    Results are in order and correct, spaced NCH+2 cycles.

Source files
------------

// File: rtl/csa_pkg.sv
// Shared definitions for the CSA datapath blocks: FSM state encoding,
// default widths and the chunk-count helper.
package csa_pkg;

   localparam int CSA_W     = 25;
   localparam int CSA_CHUNK = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } csa_state_t;

   // Chunks needed to cover s + 2c, which is W+2 bits wide.
   function automatic int nch(input int w, input int chunk);
      return (w + 2 + chunk - 1) / chunk;
   endfunction

endpackage

// File: rtl/csa_chunk_add.sv
// CHUNK-bit ripple-carry adder built from two-operand full-adder cells.
module csa_chunk_add #(
   parameter int CHUNK = 5
) (
   input  logic [CHUNK-1:0] a,
   input  logic [CHUNK-1:0] b,
   input  logic             cin,
   output logic [CHUNK-1:0] sum,
   output logic             cout
);

   logic [CHUNK:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa2
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[CHUNK];

endmodule

// File: rtl/csa_resolve.sv
// Multi-cycle carry-propagate stage: resolves a CSA sum/carry pair into one
// binary result, CHUNK bits per clock, with valid/ready on both sides.
// Optional feature: define CSA_RESOLVE_ZERO_EN to add the zero flag output.
module csa_resolve
   import csa_pkg::*;
#(
   parameter int W     = CSA_W,
   parameter int CHUNK = CSA_CHUNK
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   s_in,
   input  logic [W-1:0]   c_in,
   output logic           out_valid,
   input  logic           out_ready,
`ifdef CSA_RESOLVE_ZERO_EN
   output logic           zero,
`endif
   output logic [W+1:0]   out_sum
);

   localparam int NCH = nch(W, CHUNK);
   localparam int PW  = NCH * CHUNK;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

   csa_state_t                   state_q, state_d;
   logic [IW-1:0]                idx_q;
   logic                         carry_q;
   logic [NCH-1:0][CHUNK-1:0]    a_q, b_q, res_q;
   logic [PW-1:0]                a_load, b_load, res_flat;
   logic [CHUNK-1:0]             chunk_sum;
   logic                         chunk_cout;
   logic                         accept, last;

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign accept    = in_valid & in_ready;
   assign last      = (idx_q == IW'(NCH - 1));

   // Zero-pad the operands: A = s, B = c shifted to weight 2.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      a_load         = '0;
      b_load         = '0;
      a_load[W-1:0]  = s_in;
      b_load[W:1]    = c_in;
   end

   // Single shared chunk adder, fed with the chunk selected by idx.
   csa_chunk_add #(.CHUNK(CHUNK)) u_add (
      .a    (a_q[idx_q]),
      .b    (b_q[idx_q]),
      .cin  (carry_q),
      .sum  (chunk_sum),
      .cout (chunk_cout)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)    state_d = BUSY;
         BUSY:    if (last)      state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // Operand capture on accept.
   always_ff @(posedge clk) begin
      // NOTE: operand registers carry no reset: they are always loaded before they are read.
      if (accept) begin
         a_q <= a_load;
         b_q <= b_load;
      end
   end

   // Chunk walk: write one result chunk per BUSY cycle and ripple the carry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         carry_q <= 1'b0;
         res_q   <= '0;
      end else if (accept) begin
         idx_q   <= '0;
         carry_q <= 1'b0;
      end else if (state_q == BUSY) begin
         res_q[idx_q] <= chunk_sum;
         carry_q      <= chunk_cout;
         idx_q        <= last ? '0 : idx_q + 1'b1;
      end
   end

   assign res_flat = res_q;
   assign out_sum  = res_flat[W+1:0];

   // Padding bits above W+2 are always zero and never leave the block.
   if (PW > W + 2) begin : g_pad
      logic unused_pad;
      assign unused_pad = &{1'b0, res_flat[PW-1:W+2]};
   end

`ifdef CSA_RESOLVE_ZERO_EN
   logic zero_q;

   // Zero flag accumulated chunk by chunk so it is ready together with out_sum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 zero_q <= 1'b0;
      else if (accept)            zero_q <= 1'b1;
      else if (state_q == BUSY)   zero_q <= zero_q & (chunk_sum == '0);
   end

   assign zero = zero_q;
`endif

endmodule
